// File: rtl/warmboot_sequencer_if.sv
// Signal bundle between the bootloader/board top and the warm-boot sequencer.
// The master drives the request and USB status; the slave (sequencer) drives pull-up and SB_WARMBOOT.
interface warmboot_sequencer_if;
  logic boot_req;
  logic pll_lock;
  logic usb_tx_en;
  logic pu_en;
  logic wb_s1;
  logic wb_s0;
  logic wb_boot;
  logic busy;

  modport master (
    output boot_req, pll_lock, usb_tx_en,
    input  pu_en, wb_s1, wb_s0, wb_boot, busy
  );

  modport slave (
    input  boot_req, pll_lock, usb_tx_en,
    output pu_en, wb_s1, wb_s0, wb_boot, busy
  );
endinterface

// File: rtl/warmboot_sequencer.sv
// Sequences a clean warm reboot: drain USB TX, detach from host by dropping the D+ pull-up,
// present the image select to SB_WARMBOOT, then fire BOOT. FIRE is terminal until reset.
module warmboot_sequencer #(
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned QUIET_CYCLES  = 4800,
  parameter int unsigned DRAIN_TIMEOUT = 480000,
  parameter int unsigned DETACH_CYCLES = 480000,
  parameter int unsigned ARM_CYCLES    = 16,
  parameter logic [1:0]  IMAGE_SEL     = 2'b01
) (
  input  logic                 clk_48mhz,
  input  logic                 reset_n,
  warmboot_sequencer_if.slave  bus_io
);

  if (QUIET_CYCLES == 0 || DRAIN_TIMEOUT == 0 || DETACH_CYCLES == 0 || ARM_CYCLES == 0)
  begin : g_zero_check
    $error("warmboot_sequencer: *_CYCLES parameters must be non-zero");
  end

  if ((64'(QUIET_CYCLES) >= (64'(1) << CNT_W)) || (64'(DRAIN_TIMEOUT) >= (64'(1) << CNT_W)) ||
      (64'(DETACH_CYCLES) >= (64'(1) << CNT_W)) || (64'(ARM_CYCLES) >= (64'(1) << CNT_W)))
  begin : g_width_check
    $error("warmboot_sequencer: *_CYCLES parameters must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] QuietLast  = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DrainLast  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DetachLast = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ArmLast    = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  typedef enum logic [2:0] {StIdle, StDrain, StDetach, StArm, StFire} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] quiet_q, quiet_d;
  logic             lock_seen_q;
  logic             boot_q;
  logic             boot_edge;

  logic             pu_en_q, pu_en_d;
  logic [1:0]       sel_q, sel_d;
  logic             wb_boot_q, wb_boot_d;
  logic             busy_q, busy_d;

  // boot_q resets high so a request held through reset never counts as an edge.
  assign boot_edge = bus_io.boot_req & ~boot_q;

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      quiet_q     <= '0;
      lock_seen_q <= 1'b0;
      boot_q      <= 1'b1;
      pu_en_q     <= 1'b0;
      sel_q       <= 2'b00;
      wb_boot_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quiet_q     <= quiet_d;
      lock_seen_q <= lock_seen_q | bus_io.pll_lock;
      boot_q      <= bus_io.boot_req;
      pu_en_q     <= pu_en_d;
      sel_q       <= sel_d;
      wb_boot_q   <= wb_boot_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quiet_d = quiet_q;
    unique case (state_q)
      StIdle: begin
        if (boot_edge && lock_seen_q) begin
          cnt_d   = '0;
          quiet_d = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        cnt_d   = cnt_q + CntOne;
        quiet_d = bus_io.usb_tx_en ? '0 : quiet_q + CntOne;
        if ((!bus_io.usb_tx_en && quiet_q == QuietLast) || cnt_q == DrainLast) begin
          cnt_d   = '0;
          state_d = StDetach;
        end
      end
      StDetach: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == DetachLast) begin
          cnt_d   = '0;
          state_d = StArm;
        end
      end
      StArm: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == ArmLast) begin
          cnt_d   = '0;
          state_d = StFire;
        end
      end
      StFire: begin
        // Device reconfigures from here; nothing but reset leaves this state.
        state_d = StFire;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pu_en_d   = 1'b0;
    sel_d     = 2'b00;
    wb_boot_d = 1'b0;
    busy_d    = 1'b1;
    unique case (state_q)
      StIdle: begin
        pu_en_d = lock_seen_q;
        busy_d  = 1'b0;
      end
      StDrain:  pu_en_d = 1'b1;
      StDetach: pu_en_d = 1'b0;
      StArm:    sel_d   = IMAGE_SEL;
      StFire: begin
        sel_d     = IMAGE_SEL;
        wb_boot_d = 1'b1;
      end
      default:  busy_d  = 1'b0;
    endcase
  end

  assign bus_io.pu_en   = pu_en_q;
  assign bus_io.wb_s1   = sel_q[1];
  assign bus_io.wb_s0   = sel_q[0];
  assign bus_io.wb_boot = wb_boot_q;
  assign bus_io.busy    = busy_q;

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Self-checking bench for warmboot_sequencer: scenario tasks plus randomized USB TX traffic
// compared against a quiet-run/timeout model of the drain phase.
module tb_warmboot_sequencer;
  localparam int unsigned QUIET    = 8;
  localparam int unsigned DRAIN_TO = 64;
  localparam int unsigned DETACH   = 32;
  localparam int unsigned ARM      = 4;
  localparam logic [1:0]  IMAGE    = 2'b01;
  localparam int          RUN_LEN  = 110;

  logic clk_48mhz = 1'b0;
  logic reset_n   = 1'b0;

  warmboot_sequencer_if bus ();

  warmboot_sequencer #(
    .CNT_W         (20),
    .QUIET_CYCLES  (QUIET),
    .DRAIN_TIMEOUT (DRAIN_TO),
    .DETACH_CYCLES (DETACH),
    .ARM_CYCLES    (ARM),
    .IMAGE_SEL     (IMAGE)
  ) dut (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .bus_io    (bus)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int vectors     = 0;
  int miscompares = 0;
  bit tx_pat [0:RUN_LEN-1];

  // Drain exits at the first DRAIN cycle k ending a run of QUIET idle cycles, or at the timeout.
  function automatic int model_exit();
    int run = 0;
    for (int k = 0; k < int'(DRAIN_TO); k++) begin
      run = tx_pat[k + 1] ? 0 : run + 1;
      if (run >= int'(QUIET) || k == int'(DRAIN_TO) - 1) return k;
    end
    return int'(DRAIN_TO) - 1;
  endfunction

  task automatic fill_pattern(input int mode);
    int unsigned p = $urandom_range(1, 7);
    for (int r = 0; r < RUN_LEN; r++) begin
      case (mode)
        1:       tx_pat[r] = (r > 0) && (r % 5 == 0);
        2:       tx_pat[r] = (r >= 1) && (r <= 20);
        3:       tx_pat[r] = (r > 0) && ($urandom_range(0, p) == 0);
        default: tx_pat[r] = 1'b0;
      endcase
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  task automatic do_reset();
    bus.boot_req  = 1'b0;
    bus.pll_lock  = 1'b0;
    bus.usb_tx_en = 1'b0;
    reset_n       = 1'b0;
    repeat (3) @(posedge clk_48mhz);
    #1 reset_n = 1'b1;
  endtask

  task automatic lock_and_settle();
    bus.pll_lock = 1'b1;
    wait_cycles(4);
  endtask

  // Runs one request from an idle, locked state (edge at relative cycle 0) and checks event times.
  task automatic test_pattern(input string name, input bit extra);
    int  k_exit;
    int  busy_r = -1;
    int  pu_r   = -1;
    int  sel_r  = -1;
    int  boot_r = -1;
    bit  boot_held;
    k_exit = model_exit();
    for (int r = 0; r < RUN_LEN; r++) begin
      bus.boot_req  = (r == 0) || (extra && (r == 4 || r == 20 || r == 42 || r == 55));
      bus.usb_tx_en = tx_pat[r];
      @(negedge clk_48mhz);
      if (busy_r < 0 && bus.busy) busy_r = r;
      if (pu_r < 0 && busy_r >= 0 && !bus.pu_en) pu_r = r;
      if (sel_r < 0 && {bus.wb_s1, bus.wb_s0} == IMAGE) sel_r = r;
      if (boot_r < 0 && bus.wb_boot) boot_r = r;
      @(posedge clk_48mhz);
      #1;
    end
    boot_held     = bus.wb_boot;
    bus.boot_req  = 1'b0;
    bus.usb_tx_en = 1'b0;
    vectors += 5;
    if (busy_r !== 2) begin
      miscompares++;
      $display("FAIL %s busy_rise: got %0d required %0d", name, busy_r, 2);
    end
    if (pu_r !== 3 + k_exit) begin
      miscompares++;
      $display("FAIL %s pu_en_fall: got %0d required %0d", name, pu_r, 3 + k_exit);
    end
    if (sel_r !== 3 + k_exit + int'(DETACH)) begin
      miscompares++;
      $display("FAIL %s sel_valid: got %0d required %0d", name, sel_r, 3 + k_exit + int'(DETACH));
    end
    if (boot_r !== 3 + k_exit + int'(DETACH) + int'(ARM)) begin
      miscompares++;
      $display("FAIL %s wb_boot_rise: got %0d required %0d", name, boot_r,
               3 + k_exit + int'(DETACH) + int'(ARM));
    end
    if (boot_held !== 1'b1) begin
      miscompares++;
      $display("FAIL %s wb_boot_held: got %b required 1", name, boot_held);
    end
  endtask

  task automatic test_reset();
    bus.boot_req  = 1'b0;
    bus.pll_lock  = 1'b0;
    bus.usb_tx_en = 1'b0;
    reset_n       = 1'b0;
    #2;
    vectors++;
    if ({bus.pu_en, bus.wb_s1, bus.wb_s0, bus.wb_boot, bus.busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 00000",
               {bus.pu_en, bus.wb_s1, bus.wb_s0, bus.wb_boot, bus.busy});
    end
    do_reset();
    @(negedge clk_48mhz);
    vectors++;
    if ({bus.pu_en, bus.wb_s1, bus.wb_s0, bus.wb_boot, bus.busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL post_reset_outputs: got %b required 00000",
               {bus.pu_en, bus.wb_s1, bus.wb_s0, bus.wb_boot, bus.busy});
    end
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic test_lock_then_pulse();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      bus.pll_lock = (c >= 10);
      @(negedge clk_48mhz);
      vectors++;
      if (bus.pu_en !== (c >= 12)) begin
        miscompares++;
        $display("FAIL lock_pu_en cycle %0d: got %b required %b", c, bus.pu_en, (c >= 12));
      end
      @(posedge clk_48mhz);
      #1;
    end
    bus.pll_lock = 1'b0;  // lock_seen is sticky; dropping lock must not matter
    fill_pattern(0);
    test_pattern("lock_pulse", 1'b0);
  endtask

  task automatic test_busy_usb();
    do_reset();
    lock_and_settle();
    fill_pattern(1);
    test_pattern("drain_timeout", 1'b0);
    do_reset();
    lock_and_settle();
    fill_pattern(2);
    test_pattern("drain_quiet", 1'b0);
  endtask

  task automatic test_no_lock();
    bit bad = 1'b0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      bus.boot_req = (c == 2) || (c == 15);
      @(negedge clk_48mhz);
      if (bus.busy || bus.pu_en) bad = 1'b1;
      @(posedge clk_48mhz);
      #1;
    end
    bus.boot_req = 1'b0;
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL no_lock_ignored: busy/pu_en seen=%b required 0", bad);
    end
    lock_and_settle();
    fill_pattern(0);
    test_pattern("after_lock", 1'b0);
  endtask

  task automatic test_reset_mid_detach();
    bit bad = 1'b0;
    do_reset();
    lock_and_settle();
    for (int r = 0; r <= 20; r++) begin
      bus.boot_req = (r == 0);
      @(negedge clk_48mhz);
      if (r != 20) begin
        @(posedge clk_48mhz);
        #1;
      end
    end
    vectors++;
    if (bus.pu_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_detach_pu_en: got %b required 0", bus.pu_en);
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.pu_en, bus.wb_s1, bus.wb_s0, bus.wb_boot, bus.busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got %b required 00000",
               {bus.pu_en, bus.wb_s1, bus.wb_s0, bus.wb_boot, bus.busy});
    end
    bus.boot_req = 1'b1;
    bus.pll_lock = 1'b1;
    repeat (3) @(posedge clk_48mhz);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_48mhz);
      if (bus.busy || bus.wb_boot) bad = 1'b1;
      @(posedge clk_48mhz);
      #1;
    end
    vectors += 2;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL held_req_no_start: busy/wb_boot seen=%b required 0", bad);
    end
    if (bus.pu_en !== 1'b1) begin
      miscompares++;
      $display("FAIL pu_en_after_relock: got %b required 1", bus.pu_en);
    end
    bus.boot_req = 1'b0;
    wait_cycles(1);
    fill_pattern(0);
    test_pattern("fresh_edge", 1'b0);
  endtask

  task automatic test_repeat_requests();
    do_reset();
    lock_and_settle();
    fill_pattern(0);
    test_pattern("repeat_edges", 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      do_reset();
      lock_and_settle();
      fill_pattern(3);
      test_pattern($sformatf("random_%0d", i), 1'b0);
    end
  endtask

  // Invariants on the SB_WARMBOOT side, checked throughout every scenario.
  logic [1:0] prev_sel   = 2'b00;
  logic       prev_boot  = 1'b0;
  int         stable_cnt = 0;

  always @(negedge clk_48mhz) begin
    if (bus.wb_boot === 1'b1) begin
      vectors++;
      if (bus.pu_en !== 1'b0) begin
        miscompares++;
        $display("FAIL boot_with_pullup: pu_en=%b required 0", bus.pu_en);
      end
      if (prev_boot === 1'b0) begin
        vectors++;
        if (stable_cnt < int'(ARM) || {bus.wb_s1, bus.wb_s0} !== IMAGE) begin
          miscompares++;
          $display("FAIL select_setup: stable=%0d sel=%b required >=%0d sel=%b",
                   stable_cnt, {bus.wb_s1, bus.wb_s0}, ARM, IMAGE);
        end
      end
    end else begin
      stable_cnt = ({bus.wb_s1, bus.wb_s0} === prev_sel) ? stable_cnt + 1 : 1;
    end
    prev_sel  = {bus.wb_s1, bus.wb_s0};
    prev_boot = bus.wb_boot;
  end

  initial begin
    test_reset();
    test_lock_then_pulse();
    test_busy_usb();
    test_no_lock();
    test_reset_mid_detach();
    test_repeat_requests();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
